// File: rtl/rs_syndrome_decoder_if.sv
// Symbol stream, status and syndrome bundle between the RS receive front end and its neighbours.
// RS_ERR_COUNT_EN adds the err_count status field.
interface rs_syndrome_decoder_if #(
  parameter int unsigned M = 8,
  parameter int unsigned T = 16
) ();
  logic [M-1:0]     data_in;
  logic             data_valid;
  logic             start_decode;
  logic [M-1:0]     data_out;
  logic             data_out_valid;
  logic             error_detected;
  logic             decoding_done;
  logic             ready_for_data;
  logic [2*T*M-1:0] syndromes;
  logic [2:0]       current_state;
`ifdef RS_ERR_COUNT_EN
  logic [15:0]      err_count;

  modport master (
    output data_in, data_valid, start_decode,
    input  data_out, data_out_valid, error_detected, decoding_done, ready_for_data,
    input  syndromes, current_state, err_count
  );
  modport slave (
    input  data_in, data_valid, start_decode,
    output data_out, data_out_valid, error_detected, decoding_done, ready_for_data,
    output syndromes, current_state, err_count
  );
`else
  modport master (
    output data_in, data_valid, start_decode,
    input  data_out, data_out_valid, error_detected, decoding_done, ready_for_data,
    input  syndromes, current_state
  );
  modport slave (
    input  data_in, data_valid, start_decode,
    output data_out, data_out_valid, error_detected, decoding_done, ready_for_data,
    output syndromes, current_state
  );
`endif
endinterface

// File: rtl/rs_syndrome_decoder.sv
// RS(n,k) receive front end: on-the-fly syndromes over GF(2^8), data buffering and replay.
// Optional RS_ERR_COUNT_EN adds a saturating count of codewords with nonzero syndromes.
module rs_syndrome_decoder #(
  parameter int unsigned M         = 8,
  parameter int unsigned K         = 223,
  parameter int unsigned N         = 255,
  parameter int unsigned T         = 16,
  parameter logic [M:0]  FieldPoly = 9'h11D
) (
  input logic                  clk,
  input logic                  rst,
  rs_syndrome_decoder_if.slave bus
);
  localparam int unsigned NumSyn = 2 * T;
  localparam logic [7:0]  InLast  = 8'(N - 1);
  localparam logic [7:0]  OutLast = 8'(K - 1);
  localparam logic [7:0]  DataLen = 8'(K);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReceive = 3'd1,
    StCheck   = 3'd2,
    StOutput  = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          in_cnt_q, in_cnt_d;
  logic [7:0]          out_cnt_q, out_cnt_d;
  logic [NumSyn*M-1:0] syn_q, syn_d;
  logic                err_q, err_d;
  logic                buf_we;
  logic [M-1:0]        buffer [K];

  function automatic logic [M-1:0] gf_xtime(logic [M-1:0] a);
    return a[M-1] ? ({a[M-2:0], 1'b0} ^ FieldPoly[M-1:0]) : {a[M-2:0], 1'b0};
  endfunction

  // Multiply by alpha^p; p is constant per call site so this flattens to XORs.
  function automatic logic [M-1:0] gf_mul_alpha_pow(logic [M-1:0] a, int unsigned p);
    logic [M-1:0] r;
    r = a;
    for (int unsigned i = 0; i < p; i++) r = gf_xtime(r);
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    syn_d     = syn_q;
    err_d     = err_q;
    buf_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_decode) begin
          state_d   = StReceive;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          syn_d     = '0;
          err_d     = 1'b0;
        end
      end
      StReceive: begin
        if (bus.data_valid) begin
          // Horner step: S_j <- S_j * alpha^j + r
          for (int unsigned j = 0; j < NumSyn; j++) begin
            syn_d[j*M +: M] = gf_mul_alpha_pow(syn_q[j*M +: M], j + 1) ^ bus.data_in;
          end
          buf_we = (in_cnt_q < DataLen);
          if (in_cnt_q == InLast) state_d = StCheck;
          else                    in_cnt_d = in_cnt_q + 8'd1;
        end
      end
      StCheck: begin
        err_d   = |syn_q;
        state_d = StOutput;
      end
      StOutput: begin
        if (out_cnt_q == OutLast) state_d = StDone;
        else                      out_cnt_d = out_cnt_q + 8'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      syn_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      syn_q     <= syn_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buffer[in_cnt_q] <= bus.data_in;
  end

  assign bus.data_out       = (state_q == StOutput) ? buffer[out_cnt_q] : '0;
  assign bus.data_out_valid = (state_q == StOutput);
  assign bus.ready_for_data = (state_q == StReceive);
  assign bus.decoding_done  = (state_q == StDone);
  assign bus.error_detected = err_q;
  assign bus.syndromes      = syn_q;
  assign bus.current_state  = state_q;

`ifdef RS_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state_q == StCheck && (|syn_q) && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_rs_syndrome_decoder.sv
// Directed bench for rs_syndrome_decoder; builds codewords with a reference RS encoder.
// Define RS_ERR_COUNT_EN to also exercise the error counter.
module tb_rs_syndrome_decoder;
  localparam int N = 255;
  localparam int K = 223;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_syndrome_decoder_if #(.M(8), .T(T)) bus ();

  rs_syndrome_decoder #(.M(8), .K(K), .N(N), .T(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]       tx [N];
  logic [7:0]       rx [K];
  logic [7:0]       gen [2*T+1];
  logic [2*T*8-1:0] exp_syn;
  int               rx_n, lat, done_gap;
  bit               timed_out, err_at_out, post_done;
  logic [2:0]       post_state;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] alpha_pow(int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e % 255; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic build_gen();
    logic [7:0] nxt [2*T+1];
    for (int i = 0; i <= 2*T; i++) gen[i] = 8'h00;
    gen[0] = 8'h01;
    for (int r = 1; r <= 2*T; r++) begin
      for (int j = 0; j <= 2*T; j++)
        nxt[j] = gmul(gen[j], alpha_pow(r)) ^ ((j > 0) ? gen[j-1] : 8'h00);
      for (int j = 0; j <= 2*T; j++) gen[j] = nxt[j];
    end
  endtask

  // Systematic encode of data 1..K into tx (parity highest degree first).
  task automatic encode_count();
    logic [7:0] rem [2*T];
    logic [7:0] fb;
    for (int j = 0; j < 2*T; j++) rem[j] = 8'h00;
    for (int i = 0; i < K; i++) begin
      tx[i] = 8'(i + 1);
      fb = tx[i] ^ rem[2*T-1];
      for (int j = 2*T-1; j > 0; j--) rem[j] = rem[j-1] ^ gmul(fb, gen[j]);
      rem[0] = gmul(fb, gen[0]);
    end
    for (int j = 0; j < 2*T; j++) tx[K+j] = rem[2*T-1-j];
  endtask

  task automatic clear_tx();
    for (int i = 0; i < N; i++) tx[i] = 8'h00;
  endtask

  // Drives one codeword from tx and records replay timing/data; no checking here.
  task automatic run_cw(input bit gapped, input bit junk);
    int cyc, last_valid, done_cyc;
    rx_n = 0; lat = -1; done_cyc = -1; last_valid = -1; done_gap = -1;
    timed_out = 1'b0; err_at_out = 1'b0;
    if (junk) repeat (2) begin
      @(negedge clk); bus.data_valid = 1'b1; bus.data_in = 8'h77;
    end
    @(negedge clk); bus.start_decode = 1'b1; bus.data_valid = junk; bus.data_in = 8'hEE;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.start_decode = 1'b0; bus.data_valid = 1'b1; bus.data_in = tx[i];
      if (gapped && i < N-1) begin
        @(negedge clk); bus.data_valid = 1'b0; bus.data_in = 8'h33;
      end
    end
    cyc = 0;
    while (done_cyc < 0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (bus.data_out_valid) begin
        if (lat < 0) begin lat = cyc; err_at_out = bus.error_detected; end
        if (rx_n < K) rx[rx_n] = bus.data_out;
        rx_n++;
        last_valid = cyc;
      end
      if (bus.decoding_done) begin done_cyc = cyc; done_gap = cyc - last_valid; end
      bus.data_valid = junk; bus.data_in = 8'h55;
    end
    if (done_cyc < 0) timed_out = 1'b1;
    @(negedge clk);
    post_state = bus.current_state; post_done = bus.decoding_done;
    bus.data_valid = 1'b0;
  endtask

  function automatic int data_errors();
    int bad;
    bad = 0;
    for (int i = 0; i < K; i++) if (rx[i] !== tx[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (bus.current_state !== 3'd0) $display("FAIL reset_state got %0d want 0", bus.current_state);
    else pass_cnt++;
    total_cnt++;
    if ({bus.data_out_valid, bus.ready_for_data, bus.error_detected, bus.decoding_done} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {bus.data_out_valid, bus.ready_for_data,
               bus.error_detected, bus.decoding_done});
    else pass_cnt++;
    total_cnt++;
    if (bus.syndromes !== '0 || bus.data_out !== 8'h00)
      $display("FAIL reset_syn_data got %h/%h want 0", bus.syndromes, bus.data_out);
    else pass_cnt++;
  endtask

  task automatic test_zero_codeword();
    clear_tx();
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (timed_out) $display("FAIL zero_timeout got timeout want done"); else pass_cnt++;
    total_cnt++;
    if (bus.syndromes !== '0 || bus.error_detected !== 1'b0)
      $display("FAIL zero_syn got %h err %b want 0", bus.syndromes, bus.error_detected);
    else pass_cnt++;
    total_cnt++;
    if (rx_n !== K || data_errors() !== 0)
      $display("FAIL zero_data got n=%0d bad=%0d want n=%0d bad=0", rx_n, data_errors(), K);
    else pass_cnt++;
    total_cnt++;
    if (done_gap !== 1 || post_done !== 1'b0 || post_state !== 3'd0)
      $display("FAIL zero_done got gap=%0d after=%b st=%0d want 1/0/0",
               done_gap, post_done, post_state);
    else pass_cnt++;
  endtask

  task automatic test_clean_codeword();
    encode_count();
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (bus.syndromes !== '0 || bus.error_detected !== 1'b0 || err_at_out !== 1'b0)
      $display("FAIL clean_syn got %h err %b want 0", bus.syndromes, bus.error_detected);
    else pass_cnt++;
    total_cnt++;
    if (rx_n !== K || data_errors() !== 0 || rx[0] !== 8'd1 || rx[K-1] !== 8'd223)
      $display("FAIL clean_data got n=%0d bad=%0d want n=%0d bad=0", rx_n, data_errors(), K);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL clean_latency got %0d want 2", lat); else pass_cnt++;
  endtask

  task automatic test_single_error();
    encode_count();
    tx[100] = tx[100] ^ 8'h01;
    for (int j = 1; j <= 2*T; j++) exp_syn[(j-1)*8 +: 8] = alpha_pow(154 * j);
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (bus.error_detected !== 1'b1 || err_at_out !== 1'b1)
      $display("FAIL err_flag got %b/%b want 1", bus.error_detected, err_at_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.syndromes !== exp_syn)
      $display("FAIL err_syn got %h want %h", bus.syndromes, exp_syn);
    else pass_cnt++;
    total_cnt++;
    if (rx[100] !== 8'd100 || data_errors() !== 0)
      $display("FAIL err_data got rx100=%h bad=%0d want 64/0", rx[100], data_errors());
    else pass_cnt++;
  endtask

  task automatic test_impulses();
    clear_tx();
    tx[N-1] = 8'h01;
    for (int j = 0; j < 2*T; j++) exp_syn[j*8 +: 8] = 8'h01;
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (bus.syndromes !== exp_syn || bus.error_detected !== 1'b1)
      $display("FAIL impulse_last got %h err %b want %h", bus.syndromes, bus.error_detected,
               exp_syn);
    else pass_cnt++;
    clear_tx();
    tx[N-2] = 8'h01;
    for (int j = 1; j <= 2*T; j++) exp_syn[(j-1)*8 +: 8] = alpha_pow(j);
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (bus.syndromes !== exp_syn)
      $display("FAIL impulse_253 got %h want %h", bus.syndromes, exp_syn);
    else pass_cnt++;
    total_cnt++;
    if (bus.syndromes[7:0] !== 8'h02) $display("FAIL impulse_s1 got %h want 02",
                                               bus.syndromes[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_gapped_valid();
    encode_count();
    run_cw(1'b1, 1'b1);
    total_cnt++;
    if (timed_out || bus.syndromes !== '0 || bus.error_detected !== 1'b0)
      $display("FAIL gapped_syn got %h err %b to %b want 0", bus.syndromes,
               bus.error_detected, timed_out);
    else pass_cnt++;
    total_cnt++;
    if (rx_n !== K || data_errors() !== 0 || lat !== 2)
      $display("FAIL gapped_data got n=%0d bad=%0d lat=%0d want %0d/0/2", rx_n, data_errors(),
               lat, K);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    encode_count();
    tx[7] = tx[7] ^ 8'hA5;
    @(negedge clk); bus.start_decode = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); bus.start_decode = 1'b0; bus.data_valid = 1'b1; bus.data_in = tx[i];
    end
    @(negedge clk); bus.data_valid = 1'b0;
    total_cnt++;
    if (bus.ready_for_data !== 1'b1 || bus.syndromes === '0)
      $display("FAIL mid_busy got rdy=%b syn=%h want rdy=1 syn!=0", bus.ready_for_data,
               bus.syndromes);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total_cnt++;
    if (bus.current_state !== 3'd0 || bus.ready_for_data !== 1'b0 || bus.syndromes !== '0 ||
        bus.data_out_valid !== 1'b0 || bus.error_detected !== 1'b0)
      $display("FAIL mid_reset got st=%0d rdy=%b syn=%h want 0", bus.current_state,
               bus.ready_for_data, bus.syndromes);
    else pass_cnt++;
    encode_count();
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (timed_out || bus.error_detected !== 1'b0 || data_errors() !== 0)
      $display("FAIL mid_after got err=%b bad=%0d to=%b want 0", bus.error_detected,
               data_errors(), timed_out);
    else pass_cnt++;
  endtask

`ifdef RS_ERR_COUNT_EN
  task automatic test_err_count();
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total_cnt++;
    if (bus.err_count !== 16'd0) $display("FAIL errcnt_reset got %0d want 0", bus.err_count);
    else pass_cnt++;
    encode_count();
    tx[100] = tx[100] ^ 8'h01;
    run_cw(1'b0, 1'b0);
    run_cw(1'b0, 1'b0);
    total_cnt++;
    if (bus.err_count !== 16'd2) $display("FAIL errcnt_two got %0d want 2", bus.err_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    bus.data_in = 8'h00; bus.data_valid = 1'b0; bus.start_decode = 1'b0;
    build_gen();
    test_reset();
    test_zero_codeword();
    test_clean_codeword();
    test_single_error();
    test_impulses();
    test_gapped_valid();
    test_reset_mid();
`ifdef RS_ERR_COUNT_EN
    test_err_count();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
